// File: rtl/twos_to_float_seq.sv
// Sequential two's-complement to compact float converter.
// A W-bit sample is normalised with one left shift per cycle, then rounded
// (or truncated) into a sign/exponent/fraction triple held on a valid/ready
// output. Optional feature macro: T2F_ROUND_EN selects round-half-up;
// when undefined the fraction is truncated.
module twos_to_float_seq #(
  parameter int unsigned W = 12,
  parameter int unsigned E = 3,
  parameter int unsigned F = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s,
  output logic [E-1:0] e,
  output logic [F-1:0] f,
  output logic         sat
);

  // Magnitude never needs the top bit: |d| is clamped below 2^(W-1).
  localparam int unsigned M      = W - 1;
  localparam logic [E-1:0] E_INIT = E'(W - F - 1);
  localparam logic [E-1:0] E_MAX  = '1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t       state, state_d;
  logic [M-1:0] mag, mag_d;
  logic [E-1:0] e_reg, e_reg_d;
  logic         s_reg, s_reg_d;
  logic         sat_reg, sat_reg_d;
  logic         in_ready_d, out_valid_d;
  logic         s_d, sat_d;
  logic [E-1:0] e_d;
  logic [F-1:0] f_d;

  logic [M-1:0] d_neg;
  logic [M-1:0] d_mag;
  logic         d_min;

  logic [F-1:0] frac;
  logic [F-1:0] f_rnd;
  logic [E-1:0] e_rnd;
  logic         sat_rnd;
  logic         unused_low;

  // Absolute value of the incoming sample, clamping the most negative code.
  always_comb begin
    d_neg = ~d[M-1:0] + M'(1);
    d_min = d[W-1] && (d[M-1:0] == '0);
    if (d_min) begin
      d_mag = '1;
    end else if (d[W-1]) begin
      d_mag = d_neg;
    end else begin
      d_mag = d[M-1:0];
    end
  end

  // Fraction extraction and optional round-half-up with carry/saturation.
  always_comb begin
    frac    = mag[M-1 -: F];
    f_rnd   = frac;
    e_rnd   = e_reg;
    sat_rnd = sat_reg;
`ifdef T2F_ROUND_EN
    if (mag[M-1-F] && (frac == '1)) begin
      if (e_reg == E_MAX) begin
        e_rnd   = E_MAX;
        f_rnd   = '1;
        sat_rnd = 1'b1;
      end else begin
        e_rnd        = e_reg + E'(1);
        f_rnd        = '0;
        f_rnd[F-1]   = 1'b1;
      end
    end else begin
      f_rnd = frac + F'(mag[M-1-F]);
    end
`endif
  end

  // Bits below the kept fraction are discarded by design.
  assign unused_low = ^mag[M-1-F:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    mag_d       = mag;
    e_reg_d     = e_reg;
    s_reg_d     = s_reg;
    sat_reg_d   = sat_reg;
    out_valid_d = out_valid;
    s_d         = s;
    e_d         = e;
    f_d         = f;
    sat_d       = sat;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          s_reg_d   = d[W-1];
          mag_d     = d_mag;
          e_reg_d   = E_INIT;
          sat_reg_d = d_min;
          state_d   = NORM;
        end
      end
      NORM: begin
        if (mag[M-1] || (e_reg == '0)) begin
          state_d = ROUND;
        end else begin
          mag_d   = {mag[M-2:0], 1'b0};
          e_reg_d = e_reg - E'(1);
        end
      end
      ROUND: begin
        s_d     = s_reg;
        e_d     = e_rnd;
        f_d     = f_rnd;
        sat_d   = sat_rnd;
        state_d = DONE;
      end
      DONE: begin
        if (!out_valid) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      e_reg     <= '0;
      s_reg     <= 1'b0;
      sat_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      f         <= '0;
      sat       <= 1'b0;
    end else begin
      state     <= state_d;
      mag       <= mag_d;
      e_reg     <= e_reg_d;
      s_reg     <= s_reg_d;
      sat_reg   <= sat_reg_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      s         <= s_d;
      e         <= e_d;
      f         <= f_d;
      sat       <= sat_d;
    end
  end

endmodule

// File: tb/tb_twos_to_float_seq.sv
// Testbench for twos_to_float_seq: directed table, random samples against a
// value-level reference model, backpressure and mid-conversion reset.
module tb_twos_to_float_seq;

  localparam int unsigned W = 12;
  localparam int unsigned E = 3;
  localparam int unsigned F = 4;
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    logic [E-1:0] e;
    logic [F-1:0] f;
    logic         sat;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] d = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         s;
  logic [E-1:0] e;
  logic [F-1:0] f;
  logic         sat;

  int checks = 0;
  int errors = 0;

  twos_to_float_seq #(.W(W), .E(E), .F(F)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .e(e), .f(f), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: float fields derived from the sample's integer value.
  function automatic vec_t ref_model(input logic [W-1:0] din);
    vec_t r;
    int v, mag, p, lz, ex, fr, rb;
    v     = int'($signed(din));
    r.d   = din;
    r.s   = din[W-1];
    r.sat = 1'b0;
    mag   = (v < 0) ? -v : v;
    if (mag > MAXMAG) begin
      mag   = MAXMAG;
      r.sat = 1'b1;
    end
    p = -1;
    for (int i = 0; i < int'(W); i++) if ((mag >> i) & 1) p = i;
    lz    = int'(W) - 1 - p;
    r.lat = ((lz < int'(W - F)) ? lz : int'(W - F)) + 2;
    if (p >= int'(F) - 1) begin
      ex = p - int'(F) + 1;
      fr = mag >> ex;
      rb = (ex > 0) ? ((mag >> (ex - 1)) & 1) : 0;
    end else begin
      ex = 0;
      fr = mag;
      rb = 0;
    end
`ifdef T2F_ROUND_EN
    fr = fr + rb;
    if (fr == (1 << F)) begin
      fr = 1 << (F - 1);
      ex = ex + 1;
    end
    if (ex > (1 << E) - 1) begin
      ex    = (1 << E) - 1;
      fr    = (1 << F) - 1;
      r.sat = 1'b1;
    end
`else
    rb = 0;
`endif
    r.e = E'(ex);
    r.f = F'(fr);
    return r;
  endfunction

  // One full transaction with random busy-time noise and output stalls.
  task automatic run_one(input vec_t x, input string tag);
    int cyc;
    int hold;
    logic busy_ok;
    logic stable;
    logic [E-1:0] e0;
    logic [F-1:0] f0;
    logic s0, sat0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_idle"}, int'(in_ready), 1);
    in_valid = 1'b1;
    d        = x.d;
    step();
    d       = W'($urandom);
    cyc     = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      d        = W'($urandom);
      step();
      cyc++;
    end
    check({tag, "_lat"}, cyc, x.lat);
    check({tag, "_busy"}, int'(busy_ok), 1);
    check({tag, "_s"}, int'(s), int'(x.s));
    check({tag, "_e"}, int'(e), int'(x.e));
    check({tag, "_f"}, int'(f), int'(x.f));
    check({tag, "_sat"}, int'(sat), int'(x.sat));
    s0 = s; e0 = e; f0 = f; sat0 = sat;
    stable = 1'b1;
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      step();
      if (!out_valid || in_ready || s != s0 || e != e0 || f != f0 || sat != sat0)
        stable = 1'b0;
    end
    check({tag, "_stall"}, int'(stable), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_hs"}, int'({out_valid, in_ready}), 1);
  endtask

  vec_t tbl[12];
  vec_t v;
  logic [W-1:0] rnd;
  logic [E-1:0] e0;
  logic [F-1:0] f0;
  logic s0, sat0, stable, spur;
  int cyc;

  initial begin
`ifdef T2F_ROUND_EN
    tbl[0]  = '{12'd31,             1'b0, 3'd2, 4'b1000, 1'b0, 9};
    tbl[2]  = '{12'd46,             1'b0, 3'd2, 4'b1100, 1'b0, 8};
    tbl[3]  = '{12'b111111010010,   1'b1, 3'd2, 4'b1100, 1'b0, 8};
    tbl[6]  = '{12'b011111111111,   1'b0, 3'd7, 4'b1111, 1'b1, 3};
    tbl[11] = '{12'd1000,           1'b0, 3'd7, 4'b1000, 1'b0, 4};
`else
    tbl[0]  = '{12'd31,             1'b0, 3'd1, 4'b1111, 1'b0, 9};
    tbl[2]  = '{12'd46,             1'b0, 3'd2, 4'b1011, 1'b0, 8};
    tbl[3]  = '{12'b111111010010,   1'b1, 3'd2, 4'b1011, 1'b0, 8};
    tbl[6]  = '{12'b011111111111,   1'b0, 3'd7, 4'b1111, 1'b0, 3};
    tbl[11] = '{12'd1000,           1'b0, 3'd6, 4'b1111, 1'b0, 4};
`endif
    tbl[1]  = '{12'd44,             1'b0, 3'd2, 4'b1011, 1'b0, 8};
    tbl[4]  = '{12'b100000000000,   1'b1, 3'd7, 4'b1111, 1'b1, 3};
    tbl[5]  = '{12'd0,              1'b0, 3'd0, 4'b0000, 1'b0, 10};
    tbl[7]  = '{12'd4,              1'b0, 3'd0, 4'b0100, 1'b0, 10};
    tbl[8]  = '{12'd8,              1'b0, 3'd0, 4'b1000, 1'b0, 10};
    tbl[9]  = '{12'd1024,           1'b0, 3'd7, 4'b1000, 1'b0, 3};
    tbl[10] = '{12'b111111111111,   1'b1, 3'd0, 4'b0001, 1'b0, 10};

    // Reset state.
    repeat (2) step();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fields", int'({s, e, f, sat}), 0);
    rst = 1'b0;
    step();

    // Directed vectors.
    for (int i = 0; i < 12; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // Random samples against the reference model.
    for (int i = 0; i < 150; i++) begin
      rnd = W'($urandom);
      rnd = W'($signed(rnd) >>> $urandom_range(0, W - 1));
      v   = ref_model(rnd);
      run_one(v, $sformatf("rnd%0d_d%0h", i, rnd));
    end

    // Backpressure: result held for 20 cycles while new requests are ignored.
    in_valid = 1'b1;
    d        = tbl[3].d;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("bp_lat", cyc, tbl[3].lat);
    check("bp_f", int'(f), int'(tbl[3].f));
    s0 = s; e0 = e; f0 = f; sat0 = sat;
    stable = 1'b1;
    spur   = 1'b0;
    repeat (20) begin
      in_valid = 1'b1;
      d        = W'($urandom);
      step();
      if (!out_valid || s != s0 || e != e0 || f != f0 || sat != sat0) stable = 1'b0;
      if (in_ready) spur = 1'b1;
    end
    check("bp_stable", int'(stable), 1);
    check("bp_in_ready_low", int'(spur), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_retain", int'({s, e, f, sat}), int'({s0, e0, f0, sat0}));
    step();
    check("bp_no_accept", int'({out_valid, in_ready}), 1);

    // Reset in the middle of normalisation discards the sample.
    in_valid = 1'b1;
    d        = tbl[0].d;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_fields", int'({s, e, f, sat}), 0);
    step();
    rst = 1'b0;
    step();
    run_one(tbl[2], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
